// File: rtl/branch_update_unit_if.sv
// Prediction/resolution/table-update bundle between the fetch/execute stages and
// branch_update_unit. The unit connects through the slave modport.
interface branch_update_unit_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BHR_W = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic               pred_valid;
    logic               pred_ready;
    logic [31:0]        pred_pc;
    logic               pred_taken;
    logic [BHR_W-1:0]   pred_bhr;
    logic [1:0]         pred_pht;

    logic               res_valid;
    logic               res_taken;
    logic [31:0]        res_target;

    logic               upd_valid;
    logic [3:0]         upd_bht_idx;
    logic [BHR_W-1:0]   upd_bhr;
    logic [BHR_W+2:0]   upd_pht_idx;
    logic [1:0]         upd_pht;

    logic               flush;
    logic [31:0]        redirect_pc;

    logic [CNT_W-1:0]   count;
    logic [15:0]        stat_resolved;
    logic [15:0]        stat_mispred;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_bhr, pred_pht,
        output res_valid, res_taken, res_target,
        input  pred_ready,
        input  upd_valid, upd_bht_idx, upd_bhr, upd_pht_idx, upd_pht,
        input  flush, redirect_pc, count, stat_resolved, stat_mispred
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_bhr, pred_pht,
        input  res_valid, res_taken, res_target,
        output pred_ready,
        output upd_valid, upd_bht_idx, upd_bhr, upd_pht_idx, upd_pht,
        output flush, redirect_pc, count, stat_resolved, stat_mispred
    );
endinterface

// File: rtl/branch_update_unit.sv
// In-order queue of issued branch predictions, retired on resolve into a registered
// BHT/PHT write-back plus mispredict flush. Define BRU_STATS_EN to build the statistics counters.
module branch_update_unit #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned BHR_W = 4
) (
    input logic                 clk,
    input logic                 resetn,
    branch_update_unit_if.slave bus
);
    localparam int unsigned    PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [31:0]      r_q_pc    [DEPTH];
    logic             r_q_taken [DEPTH];
    logic [BHR_W-1:0] r_q_bhr   [DEPTH];
    logic [1:0]       r_q_pht   [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   r_head;
    logic [PTR_W:0]   r_tail;

    logic             r_upd_valid;
    logic [3:0]       r_upd_bht_idx;
    logic [BHR_W-1:0] r_upd_bhr;
    logic [BHR_W+2:0] r_upd_pht_idx;
    logic [1:0]       r_upd_pht;
    logic             r_flush;
    logic [31:0]      r_redirect_pc;

    logic [PTR_W:0]   w_count;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_mispred;

    logic [31:0]      w_head_pc;
    logic             w_head_taken;
    logic [BHR_W-1:0] w_head_bhr;
    logic [1:0]       w_head_pht;

    logic [3:0]       w_bht_idx;
    logic [BHR_W-1:0] w_new_bhr;
    logic [BHR_W+2:0] w_pht_idx;
    logic [1:0]       w_new_pht;
    logic [31:0]      w_redirect_pc;

    assign w_count = r_tail - r_head;
    assign w_ready = (w_count < FULL_COUNT);
    assign w_push  = bus.pred_valid & w_ready;
    assign w_pop   = bus.res_valid & (w_count != '0);

    assign w_head_pc    = r_q_pc[r_head[PTR_W-1:0]];
    assign w_head_taken = r_q_taken[r_head[PTR_W-1:0]];
    assign w_head_bhr   = r_q_bhr[r_head[PTR_W-1:0]];
    assign w_head_pht   = r_q_pht[r_head[PTR_W-1:0]];

    assign w_mispred = (bus.res_taken != w_head_taken);

    always_comb begin
        w_bht_idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            w_bht_idx = w_bht_idx ^ w_head_pc[i*4 +: 4];
        end
    end

    // Index uses the history snapshot taken at prediction time, not the updated history.
    assign w_new_bhr = {w_head_bhr[BHR_W-2:0], bus.res_taken};
    assign w_pht_idx = {w_head_pc[2:0], w_head_bhr};

    always_comb begin
        w_new_pht = w_head_pht;
        if (bus.res_taken) begin
            if (w_head_pht != 2'b11) begin
                w_new_pht = w_head_pht + 2'd1;
            end
        end else begin
            if (w_head_pht != 2'b00) begin
                w_new_pht = w_head_pht - 2'd1;
            end
        end
    end

    assign w_redirect_pc = bus.res_taken ? bus.res_target : (w_head_pc + 32'd4);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail[PTR_W-1:0]]    <= bus.pred_pc;
            r_q_taken[r_tail[PTR_W-1:0]] <= bus.pred_taken;
            r_q_bhr[r_tail[PTR_W-1:0]]   <= bus.pred_bhr;
            r_q_pht[r_tail[PTR_W-1:0]]   <= bus.pred_pht;
        end
    end

    // A mispredict empties the queue; a push in the same cycle is dropped by leaving tail alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (w_pop && w_mispred) begin
            r_head <= r_tail;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_upd_valid   <= 1'b0;
            r_upd_bht_idx <= '0;
            r_upd_bhr     <= '0;
            r_upd_pht_idx <= '0;
            r_upd_pht     <= '0;
            r_flush       <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_upd_valid <= w_pop;
            r_flush     <= w_pop & w_mispred;
            if (w_pop) begin
                r_upd_bht_idx <= w_bht_idx;
                r_upd_bhr     <= w_new_bhr;
                r_upd_pht_idx <= w_pht_idx;
                r_upd_pht     <= w_new_pht;
            end
            if (w_pop && w_mispred) begin
                r_redirect_pc <= w_redirect_pc;
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [15:0] r_stat_resolved;
    logic [15:0] r_stat_mispred;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_resolved <= '0;
            r_stat_mispred  <= '0;
        end else if (w_pop) begin
            if (r_stat_resolved != '1) begin
                r_stat_resolved <= r_stat_resolved + 16'd1;
            end
            if (w_mispred && (r_stat_mispred != '1)) begin
                r_stat_mispred <= r_stat_mispred + 16'd1;
            end
        end
    end

    assign bus.stat_resolved = r_stat_resolved;
    assign bus.stat_mispred  = r_stat_mispred;
`else
    assign bus.stat_resolved = '0;
    assign bus.stat_mispred  = '0;
`endif

    assign bus.pred_ready  = w_ready;
    assign bus.count       = w_count;
    assign bus.upd_valid   = r_upd_valid;
    assign bus.upd_bht_idx = r_upd_bht_idx;
    assign bus.upd_bhr     = r_upd_bhr;
    assign bus.upd_pht_idx = r_upd_pht_idx;
    assign bus.upd_pht     = r_upd_pht;
    assign bus.flush       = r_flush;
    assign bus.redirect_pc = r_redirect_pc;
endmodule

// File: tb/tb_branch_update_unit.sv
// Bench for branch_update_unit: directed scenarios plus randomized traffic checked every
// cycle against a queue-based reference model.
module tb_branch_update_unit;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BHR_W = 4;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        int          bhr;
        int          pht;
    } entry_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    branch_update_unit_if #(.DEPTH(DEPTH), .BHR_W(BHR_W)) bus ();

    branch_update_unit #(.DEPTH(DEPTH), .BHR_W(BHR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    entry_t      mq[$];
    logic        exp_upd_valid = 1'b0;
    logic        exp_flush     = 1'b0;
    int          exp_bht       = 0;
    int          exp_bhr       = 0;
    int          exp_pht_idx   = 0;
    int          exp_pht       = 0;
    logic [31:0] exp_redirect  = '0;
    int          exp_resolved  = 0;
    int          exp_mispred   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        exp_upd_valid = 1'b0;
        exp_flush     = 1'b0;
        exp_resolved  = 0;
        exp_mispred   = 0;
    endtask

    task automatic model_step(input bit pv, input logic [31:0] pc, input bit pt, input int bhr,
                              input int pht, input bit rv, input bit rt, input logic [31:0] tgt);
        bit     push;
        bit     pop;
        bit     mis;
        entry_t e;
        entry_t n;
        push = pv && (mq.size() < DEPTH);
        pop  = rv && (mq.size() != 0);
        mis  = 1'b0;
        exp_upd_valid = pop;
        exp_flush     = 1'b0;
        if (pop) begin
            e = mq.pop_front();
            exp_bht = 0;
            for (int i = 0; i < 8; i++) exp_bht = exp_bht ^ int'((e.pc >> (4 * i)) & 32'hF);
            exp_bhr     = (e.bhr * 2 + int'(rt)) % (1 << BHR_W);
            exp_pht_idx = int'(e.pc % 8) * (1 << BHR_W) + e.bhr;
            if (rt) exp_pht = (e.pht == 3) ? 3 : e.pht + 1;
            else    exp_pht = (e.pht == 0) ? 0 : e.pht - 1;
            mis       = (rt != e.taken);
            exp_flush = mis;
            if (mis) exp_redirect = rt ? tgt : e.pc + 32'd4;
`ifdef BRU_STATS_EN
            if (exp_resolved < 65535) exp_resolved++;
            if (mis && exp_mispred < 65535) exp_mispred++;
`endif
        end
        if (push) begin
            n.pc = pc; n.taken = pt; n.bhr = bhr; n.pht = pht;
            mq.push_back(n);
        end
        if (mis) mq.delete();
    endtask

    task automatic check_outputs();
        check("count", 32'(bus.count), mq.size());
        check("pred_ready", 32'(bus.pred_ready), 32'(mq.size() < DEPTH));
        check("upd_valid", 32'(bus.upd_valid), 32'(exp_upd_valid));
        check("flush", 32'(bus.flush), 32'(exp_flush));
        if (exp_upd_valid) begin
            check("upd_bht_idx", 32'(bus.upd_bht_idx), exp_bht);
            check("upd_bhr", 32'(bus.upd_bhr), exp_bhr);
            check("upd_pht_idx", 32'(bus.upd_pht_idx), exp_pht_idx);
            check("upd_pht", 32'(bus.upd_pht), exp_pht);
        end
        if (exp_flush) check("redirect_pc", bus.redirect_pc, exp_redirect);
        check("stat_resolved", 32'(bus.stat_resolved), exp_resolved);
        check("stat_mispred", 32'(bus.stat_mispred), exp_mispred);
    endtask

    // Called at a falling edge: drive, step the model, let one rising edge pass, compare.
    task automatic drive_cycle(input bit pv, input logic [31:0] pc, input bit pt, input int bhr,
                               input int pht, input bit rv, input bit rt, input logic [31:0] tgt);
        bus.pred_valid = pv;
        bus.pred_pc    = pc;
        bus.pred_taken = pt;
        bus.pred_bhr   = BHR_W'(bhr);
        bus.pred_pht   = 2'(pht);
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        bus.res_target = tgt;
        model_step(pv, pc, pt, bhr, pht, rv, rt, tgt);
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.pred_valid = 1'b0;
        bus.pred_pc    = '0;
        bus.pred_taken = 1'b0;
        bus.pred_bhr   = '0;
        bus.pred_pht   = '0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        bus.res_target = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        resetn = 1'b1;
    endtask

    initial begin
        bit          pv, pt, rv, rt;
        logic [31:0] pc, tgt;
        int          push_pct;

        idle_inputs();
        #1;
        check("rst_count", 32'(bus.count), 0);
        check("rst_pred_ready", 32'(bus.pred_ready), 1);
        check("rst_upd_valid", 32'(bus.upd_valid), 0);
        check("rst_upd_fields", {bus.upd_bht_idx, bus.upd_bhr, bus.upd_pht_idx, bus.upd_pht}, 0);
        check("rst_flush", 32'(bus.flush), 0);
        check("rst_redirect_pc", bus.redirect_pc, 0);
        check("rst_stats", {bus.stat_resolved, bus.stat_mispred}, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Correctly predicted taken branch.
        drive_cycle(1, 32'h0000_1000, 1, 4'b0101, 2'b10, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 1, 32'h0000_4000);
        check("t1_upd_valid", 32'(bus.upd_valid), 1);
        check("t1_bht_idx", 32'(bus.upd_bht_idx), 32'h1);
        check("t1_bhr", 32'(bus.upd_bhr), 32'b1011);
        check("t1_pht_idx", 32'(bus.upd_pht_idx), 32'b000_0101);
        check("t1_pht", 32'(bus.upd_pht), 32'b11);
        check("t1_flush", 32'(bus.flush), 0);

        // Predicted taken, resolved not taken: fall-through redirect.
        drive_cycle(1, 32'h0000_2004, 1, 4'b0000, 2'b11, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 0, 32'h0000_3000);
        check("t2_flush", 32'(bus.flush), 1);
        check("t2_redirect", bus.redirect_pc, 32'h0000_2008);
        check("t2_pht", 32'(bus.upd_pht), 32'b10);
        check("t2_count", 32'(bus.count), 0);

        // Fill to DEPTH, then a refused push alongside a pop.
        for (int k = 1; k <= 8; k++) drive_cycle(1, 32'(k) << 4, 1, k, 2, 0, 0, 0);
        check("t3_full_count", 32'(bus.count), 8);
        check("t3_full_ready", 32'(bus.pred_ready), 0);
        drive_cycle(1, 32'h0000_0900, 0, 9, 1, 1, 1, 0);
        check("t3_count_after", 32'(bus.count), 7);
        for (int k = 0; k < 7; k++) drive_cycle(0, 0, 0, 0, 0, 1, 1, 0);
        check("t3_drained", 32'(bus.count), 0);
        check("t3_last_pht_idx", 32'(bus.upd_pht_idx), 32'h08);

        // Mispredict on head with a simultaneous push: push is discarded.
        for (int k = 0; k < 3; k++) drive_cycle(1, 32'h100 + 32'(k * 4), 0, k, 1, 0, 0, 0);
        drive_cycle(1, 32'h0000_0500, 0, 3, 1, 1, 1, 32'h0000_7000);
        check("t4_count", 32'(bus.count), 0);
        check("t4_redirect", bus.redirect_pc, 32'h0000_7000);
        drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        check("t4_no_upd", 32'(bus.upd_valid), 0);

        // Saturation and statistics over 5 resolves with 2 mispredicts.
        do_reset();
        drive_cycle(1, 32'h0000_0010, 0, 0, 2'b00, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        check("t5_sat_low", 32'(bus.upd_pht), 0);
        drive_cycle(1, 32'h0000_0020, 1, 0, 2'b11, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 1, 0);
        check("t5_sat_high", 32'(bus.upd_pht), 3);
        drive_cycle(1, 32'h0000_0030, 1, 1, 2, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        drive_cycle(1, 32'h0000_0040, 0, 2, 1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 1, 32'h0000_8888);
        check("t5_redirect", bus.redirect_pc, 32'h0000_8888);
        drive_cycle(1, 32'h0000_0050, 1, 3, 2, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 1, 1, 0);
`ifdef BRU_STATS_EN
        check("t5_stat_resolved", 32'(bus.stat_resolved), 5);
        check("t5_stat_mispred", 32'(bus.stat_mispred), 2);
`else
        check("t5_stat_resolved", 32'(bus.stat_resolved), 0);
        check("t5_stat_mispred", 32'(bus.stat_mispred), 0);
`endif

        // Reset in the middle of a resolve with 4 entries queued.
        for (int k = 0; k < 4; k++) drive_cycle(1, 32'h600 + 32'(k * 4), 1, k, 2, 0, 0, 0);
        check("t6_pre_count", 32'(bus.count), 4);
        bus.res_valid  = 1'b1;
        bus.res_taken  = 1'b0;
        bus.res_target = 32'h0000_9000;
        #2 resetn = 1'b0;
        #1;
        check("t6_count", 32'(bus.count), 0);
        check("t6_ready", 32'(bus.pred_ready), 1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("t6_upd_valid", 32'(bus.upd_valid), 0);
        check("t6_flush", 32'(bus.flush), 0);
        check_outputs();
        resetn = 1'b1;
        drive_cycle(0, 0, 0, 0, 0, 1, 0, 0);

        // Randomized traffic with varying push pressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if (c % 700 == 699) do_reset();
            push_pct = ((c / 200) % 2 == 0) ? 75 : 35;
            pv  = ($urandom_range(0, 99) < push_pct);
            pc  = $urandom;
            pt  = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 99) < 50);
            tgt = $urandom;
            if (mq.size() != 0 && $urandom_range(0, 99) < 80) rt = mq[0].taken;
            else rt = 1'($urandom_range(0, 1));
            drive_cycle(pv, pc, pt, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                        rv, rt, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
